qif_synapse_drive: RTL and testbench
====================================

# qif_synapse_drive

Synaptic current generator placed directly upstream of the QIF neuron. Converts a vector of binary presynaptic spikes into the signed 8-bit `I_syn` current the neuron integrates. Each spike adds a programmable signed weight; the accumulated current decays exponentially via a shift-based leak on a prescaled tick. The output saturates to the signed 8-bit range, and a sticky flag reports saturation.

## Interface
- `N_IN`, 4: number of presynaptic spike inputs (1..16)
- `DECAY_SHIFT`, 3: leak strength; per tick the current magnitude drops by |I| >> DECAY_SHIFT (1..7)
- `DECAY_PERIOD`, 4: clk cycles between leak ticks; 0 disables the leak entirely
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-high
- `enable`  in  1  when low: all state frozen and spikes dropped
- `spike_in`  in  N_IN  one bit per presynaptic source, level-sampled each cycle
- `wt_we`  in  1  weight write strobe
- `wt_addr`  in  clog2(N_IN) (min 1)  weight index
- `wt_data`  in  8  signed weight
- `sat_clr`  in  1  clears `sat`
- `I_syn`  out  8  signed synaptic current, registered
- `sat`  out  1  sticky: set when any accumulation clamped

## Operation
- Weight bank: N_IN signed 8-bit registers, all reset to 0. Writes take effect at the clock edge when `wt_we` is high; out-of-range `wt_addr` is ignored.
- Stage 1 (sum): if `enable`, register S1 = sum of weights for set bits of `spike_in`. Width is 8+clog2(N_IN)+1 bits, signed, with no overflow. If `enable` is low, S1 holds.
- Leak prescaler: the counter runs 0..DECAY_PERIOD-1 while `enable` is high and wraps. The tick is asserted in the cycle the counter equals DECAY_PERIOD-1. The counter holds while `enable` is low. With DECAY_PERIOD=0, the tick is never asserted.
- Stage 2 (accumulate), when `enable` is high:
  - Leak first, on tick: compute m = |I| >> DECAY_SHIFT. If I≠0 and m=0, then m=1. The leaked value is I' = I − sign(I)·m. The leak is symmetric, moves toward zero, and never crosses zero. For -128, |I| = 128 is computed in 9-bit unsigned.
  - Then add: the sum I' + S1 is computed at full width and clamped to [-128, 127]. If a clamp occurred, `sat` is set the same edge.
  - S1 is consumed exactly once: it is zeroed internally after use. A single-cycle spike therefore contributes once, not on every cycle.
- `sat`: set by a clamp, cleared by `sat_clr`. If a clamp and `sat_clr` occur in the same cycle, the set wins.
- Weight write and spike on the same index in the same cycle: the spike uses the old weight.
- Reset values: `I_syn`=0, `sat`=0, S1=0, prescaler=0, all weights=0. Reset is asynchronous and valid mid-operation, including with spikes in flight; any in-flight S1 is discarded.

## Timing
- Spike sampled at edge n lands in `I_syn` at edge n+1: latency is 2 cycles from spike assertion to a visible `I_syn` change.
- Spikes held high for k cycles contribute k times.
- A weight write at edge n is used by spikes sampled at edge n+1 and later.
- The leak applies once per DECAY_PERIOD cycles of enabled time, independent of spike activity.
- `enable` deassertion freezes the pipeline, prescaler and `I_syn` on the next edge. Spikes during the low period are lost. Weight writes remain active while `enable` is low.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `qif_pkg` holds:
  - the `I_SYN_W`=8 constant
  - the `qif_current_t` signed 8-bit typedef, also used by the neuron's `I_syn` port
  - the `sat_s8` function, which clamps a wide signed value to the signed 8-bit range
- Sub-module `qif_weight_bank`: the register file with a write port and N_IN parallel read ports, plus the masked adder tree producing the registered S1.
- The top level holds the prescaler, leak and saturation logic.

## Test plan
- Reset: drive spikes and writes, pulse `rst_n` asynchronously mid-cycle → `I_syn`=0 and `sat`=0 immediately; after release, a spike on any input yields 0 because all weights are 0.
- Summation (DECAY_PERIOD=0): w0=40, w1=50; `spike_in`=0011 for 1 cycle at edge 10 → `I_syn`=90 at edge 11 and held indefinitely.
- Saturation: w0=100; spike0 for 2 cycles → `I_syn` 100 then 127, `sat`=1; pulse `sat_clr` → `sat`=0, `I_syn` stays 127. w0=-100 for 2 spikes from 0 → -100 then -128.
- Leak (SHIFT=3, PERIOD=4): load `I_syn`=80, no spikes → successive ticks give 70, 62, 55, 49, …, reaching 0 and holding. Start from -80 → -70, -62, … (symmetric). From 5 → 4, 3, 2, 1, 0.
- Collision: w2=10; same cycle `wt_we`(addr 2, -30) and spike2 → +10 applied; next spike2 → -30 applied.
- `enable`: `I_syn`=62, drop `enable` for 20 cycles with spikes toggling → `I_syn` constant and prescaler phase preserved; re-enable → the leak resumes at the same count.

Source files
------------

// File: rtl/qif_pkg.sv
// Shared QIF datapath types: synaptic current width, current type and 8-bit clamp.
// Used by both the synapse driver and the neuron's I_syn port.
package qif_pkg;

  localparam int I_SYN_W = 8;
  localparam int I_MAX   = (2 ** (I_SYN_W - 1)) - 1;
  localparam int I_MIN   = -(2 ** (I_SYN_W - 1));

  typedef logic signed [I_SYN_W-1:0] qif_current_t;

  function automatic qif_current_t sat_s8(input int v);
    if (v > I_MAX) return qif_current_t'(I_MAX);
    else if (v < I_MIN) return qif_current_t'(I_MIN);
    else return qif_current_t'(v);
  endfunction

endpackage

// File: rtl/qif_weight_bank.sv
// Signed weight registers plus masked adder tree; S1 registered one cycle after spike sampling.
// No backpressure: enable low holds S1 and drops spikes, weight writes always accepted.
module qif_weight_bank
  import qif_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int AW   = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int SW   = I_SYN_W + $clog2(N_IN) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_IN-1:0]      spike_in,
  input  logic                 wt_we,
  input  logic [AW-1:0]        wt_addr,
  input  qif_current_t         wt_data,
  output logic signed [SW-1:0] s1
);

  qif_current_t         wt [N_IN];
  logic signed [SW-1:0] sum;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < N_IN; i++) wt[i] <= '0;
    end else if (wt_we && (int'(wt_addr) < N_IN)) begin
      wt[wt_addr] <= wt_data;
    end
  end

  // Reads the pre-edge bank, so a same-cycle write to a spiking index is seen one cycle later.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) sum = sum + SW'(wt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) s1 <= '0;
    else if (enable) s1 <= sum;
  end

endmodule

// File: rtl/qif_synapse_drive.sv
// Spike-to-current driver: weighted sum, prescaled shift leak, clamp to s8; 2-cycle spike latency.
// No backpressure: enable low freezes S1, prescaler and I_syn; sat is sticky until sat_clr.
module qif_synapse_drive
  import qif_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enable,
  input  logic [N_IN-1:0]                        spike_in,
  input  logic                                   wt_we,
  input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] wt_addr,
  input  qif_current_t                           wt_data,
  input  logic                                   sat_clr,
  output qif_current_t                           I_syn,
  output logic                                   sat
);

  localparam int AW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SW   = I_SYN_W + $clog2(N_IN) + 1;
  localparam int PW   = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int LAST = (DECAY_PERIOD > 0) ? DECAY_PERIOD - 1 : 0;

  logic signed [SW-1:0] s1;
  logic [PW-1:0]        pre_cnt;
  logic                 tick;
  int                   cur, mag, step, leaked, total;
  logic                 clamp;
  qif_current_t         nxt;

  qif_weight_bank #(
    .N_IN (N_IN),
    .AW   (AW),
    .SW   (SW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .spike_in (spike_in),
    .wt_we    (wt_we),
    .wt_addr  (wt_addr),
    .wt_data  (wt_data),
    .s1       (s1)
  );

  assign tick = (DECAY_PERIOD != 0) && (pre_cnt == PW'(LAST));

  // Leak toward zero by at least one LSB, then add this cycle's S1 and clamp.
  always_comb begin
    cur    = int'(I_syn);
    mag    = (cur < 0) ? -cur : cur;
    step   = mag >>> DECAY_SHIFT;
    if ((cur != 0) && (step == 0)) step = 1;
    leaked = cur;
    if (tick) leaked = (cur < 0) ? cur + step : cur - step;
    total  = leaked + int'(s1);
    clamp  = (total > I_MAX) || (total < I_MIN);
    nxt    = sat_s8(total);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pre_cnt <= '0;
      I_syn   <= '0;
      sat     <= 1'b0;
    end else begin
      if (enable) begin
        I_syn <= nxt;
        if (DECAY_PERIOD != 0) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end
      if (enable && clamp) sat <= 1'b1;
      else if (sat_clr) sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qif_synapse_drive.sv
// Bench for qif_synapse_drive: leaking and non-leaking instances on shared stimulus.
// Directed vector table, hand sequences for leak/enable/reset, then random against a reference model.
module tb_qif_synapse_drive;
  import qif_pkg::*;

  localparam int N_IN   = 4;
  localparam int SHIFT  = 3;
  localparam int PERIOD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b1;
  logic [3:0]   spike_in = '0;
  logic         wt_we = 1'b0;
  logic [1:0]   wt_addr = '0;
  qif_current_t wt_data = '0;
  logic         sat_clr = 1'b0;
  qif_current_t i_lk, i_nl;
  logic         sat_lk, sat_nl;

  always #5 clk = ~clk;

  qif_synapse_drive #(.N_IN(N_IN), .DECAY_SHIFT(SHIFT), .DECAY_PERIOD(PERIOD)) u_lk (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .sat_clr(sat_clr), .I_syn(i_lk), .sat(sat_lk));

  qif_synapse_drive #(.N_IN(N_IN), .DECAY_SHIFT(SHIFT), .DECAY_PERIOD(0)) u_nl (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .sat_clr(sat_clr), .I_syn(i_nl), .sat(sat_nl));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integers, one update per enabled clock edge.
  int m_w [N_IN];
  int m_s1, m_ilk, m_inl, m_cnt;
  bit m_slk, m_snl;

  task automatic m_reset();
    for (int i = 0; i < N_IN; i++) m_w[i] = 0;
    m_s1 = 0; m_ilk = 0; m_inl = 0; m_cnt = 0; m_slk = 0; m_snl = 0;
  endtask

  task automatic m_acc(input int i, input bit s, input bit tk, output int io, output bit so);
    int v, mag, st;
    v = i;
    if (tk && i != 0) begin
      mag = (i < 0) ? -i : i;
      st  = mag >> SHIFT;
      if (st == 0) st = 1;
      v = (i > 0) ? i - st : i + st;
    end
    v  = v + m_s1;
    so = s;
    if (v > 127) begin v = 127; so = 1; end
    else if (v < -128) begin v = -128; so = 1; end
    else if (sat_clr) so = 0;
    io = v;
  endtask

  task automatic m_update();
    int sum;
    if (enable) begin
      sum = 0;
      for (int i = 0; i < N_IN; i++) if (spike_in[i]) sum += m_w[i];
      m_acc(m_ilk, m_slk, (m_cnt == PERIOD - 1), m_ilk, m_slk);
      m_acc(m_inl, m_snl, 1'b0, m_inl, m_snl);
      m_cnt = (m_cnt + 1) % PERIOD;
      m_s1  = sum;
    end else if (sat_clr) begin
      m_slk = 0;
      m_snl = 0;
    end
    if (wt_we && int'(wt_addr) < N_IN) m_w[wt_addr] = int'(wt_data);
  endtask

  task automatic step();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic drive(input int en, input int sp, input int we, input int addr,
                       input int data, input int clr);
    enable   = (en != 0);
    spike_in = 4'(sp);
    wt_we    = (we != 0);
    wt_addr  = 2'(addr);
    wt_data  = qif_current_t'(data);
    sat_clr  = (clr != 0);
  endtask

  // Called at a falling edge; pulses reset between clock edges.
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    m_reset();
    #1;
    #1 rst_n = 1'b0;
  endtask

  task automatic leak_seq(input string nm, input int w, input int e1, input int e2,
                          input int e3, input int e4);
    do_reset();
    drive(1, 0, 1, 0, w, 0);      step();
    drive(1, 4'b0001, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0);      step();
    check({nm, "_load"}, int'(i_lk), w);
    step();                 check({nm, "_t1"}, int'(i_lk), e1);
    step();                 check({nm, "_hold"}, int'(i_lk), e1);
    repeat (3) step();      check({nm, "_t2"}, int'(i_lk), e2);
    repeat (4) step();      check({nm, "_t3"}, int'(i_lk), e3);
    repeat (4) step();      check({nm, "_t4"}, int'(i_lk), e4);
    repeat (320) step();    check({nm, "_zero"}, int'(i_lk), 0);
  endtask

  typedef struct {
    int en, sp, we, addr, data, clr, ei, es;
  } vec_t;

  function automatic vec_t mk(int en, int sp, int we, int addr, int data, int clr, int ei, int es);
    vec_t v;
    v.en = en; v.sp = sp; v.we = we; v.addr = addr; v.data = data; v.clr = clr; v.ei = ei; v.es = es;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Rows drive the non-leaking instance: en, spikes, we, addr, data, clr -> I_syn, sat.
    tbl.push_back(mk(1, 4'b0000, 1, 0,   40, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 1,   50, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0,   90, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0,   90, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0,   90, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 1,  -90, 0,   90, 0));
    tbl.push_back(mk(1, 4'b0010, 0, 0,    0, 0,   90, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0,  100, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0,    0, 0,  100, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0,  127, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 1,  127, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0,  127, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 2, -127, 0,  127, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 0,    0, 0,  127, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, -100, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0,    0, 0, -100, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0, -128, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0, -128, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 0,    0, 1, -128, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 1, -128, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 0,    0, 0, -128, 1));

    m_reset();
    repeat (2) @(negedge clk);
    check("rst_i_lk", int'(i_lk), 0);
    check("rst_i_nl", int'(i_nl), 0);
    check("rst_sat_lk", int'(sat_lk), 0);
    check("rst_sat_nl", int'(sat_nl), 0);
    rst_n = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].sp, tbl[k].we, tbl[k].addr, tbl[k].data, tbl[k].clr);
      step();
      check($sformatf("tbl%0d_i", k), int'(i_nl), tbl[k].ei);
      check($sformatf("tbl%0d_sat", k), int'(sat_nl), tbl[k].es);
    end

    // Same-cycle write and spike on index 2: old weight first, new weight next.
    do_reset();
    drive(1, 0, 1, 2, 10, 0);        step();
    drive(1, 4'b0100, 1, 2, -30, 0); step();
    check("coll_0", int'(i_nl), 0);
    drive(1, 4'b0100, 0, 0, 0, 0);   step();
    check("coll_old", int'(i_nl), 10);
    drive(1, 0, 0, 0, 0, 0);         step();
    check("coll_new", int'(i_nl), -20);

    leak_seq("leak_p80", 80, 70, 62, 55, 49);
    leak_seq("leak_n80", -80, -70, -62, -55, -49);
    leak_seq("leak_p5", 5, 4, 3, 2, 1);
    leak_seq("leak_n128", -128, -112, -98, -86, -76);
    leak_seq("leak_p127", 127, 112, 98, 86, 76);

    // Freeze with enable low, prescaler two edges short of a tick.
    do_reset();
    drive(1, 0, 1, 0, 80, 0);      step();
    drive(1, 4'b0001, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0);
    repeat (8) step();
    check("en_pre", int'(i_lk), 62);
    for (int c = 0; c < 20; c++) begin
      drive(0, (c % 2 == 0) ? 4'b1111 : 4'b0000, (c == 5) ? 1 : 0, 1, 20, 0);
      step();
      check($sformatf("en_frozen%0d", c), int'(i_lk), 62);
    end
    drive(1, 0, 0, 0, 0, 0);
    step(); check("en_resume_hold", int'(i_lk), 62);
    step(); check("en_resume_tick", int'(i_lk), 55);
    drive(1, 4'b0010, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0);       step();
    check("en_write_kept", int'(i_lk), 75);

    // Asynchronous reset with saturated state and spikes in flight.
    do_reset();
    drive(1, 0, 1, 0, 100, 0);     step();
    drive(1, 4'b0001, 0, 0, 0, 0); repeat (3) step();
    check("ar_pre_i", int'(i_nl), 127);
    check("ar_pre_sat", int'(sat_nl), 1);
    drive(1, 4'b1111, 1, 1, 55, 0);
    #2 rst_n = 1'b1;
    #1;
    check("ar_i_lk", int'(i_lk), 0);
    check("ar_i_nl", int'(i_nl), 0);
    check("ar_sat_nl", int'(sat_nl), 0);
    m_reset();
    #1 rst_n = 1'b0;
    drive(1, 4'b1111, 0, 0, 0, 0); step(); step();
    check("ar_post_lk", int'(i_lk), 0);
    check("ar_post_nl", int'(i_nl), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 9) != 0) ? 1 : 0,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) - 128
                                        : int'($urandom_range(0, 80)) - 40,
            ($urandom_range(0, 9) == 0) ? 1 : 0);
      step();
      check($sformatf("rnd%0d_i_lk", c), int'(i_lk), m_ilk);
      check($sformatf("rnd%0d_sat_lk", c), int'(sat_lk), int'(m_slk));
      check($sformatf("rnd%0d_i_nl", c), int'(i_nl), m_inl);
      check($sformatf("rnd%0d_sat_nl", c), int'(sat_nl), int'(m_snl));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
